input_frontend: RTL and testbench

Parametrised input-conditioning front end for the SoC. It synchronises and debounces NUM_PB push buttons and a DIN_WIDTH switch bank, and raises per-button edge events with a selectable edge mode plus sticky event flags. A selected button latches the debounced switch word into a data register guarded by a valid/ack handshake with overrun detection. It replaces the per-bit debounce/edge-detector instances and the button-latched din register at SoC top level.

---
 rtl/input_frontend.sv | 118 +++++++++++
 tb/tb_input_frontend.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_frontend.sv
// Input-conditioning front end: synchronises and debounces push buttons and a
// switch bank, generates per-button edge events, sticky flags and a latched data word.
module input_frontend #(
  parameter int NUM_PB        = 4,
  parameter int DIN_WIDTH     = 8,
  parameter int CLK_PERIOD_NS = 20,
  parameter int DEBOUNCE_NS   = 30_000_000,
  parameter int LATCH_PB      = 3,
  parameter bit PB_ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_PB-1:0]      pb_raw,
  input  logic [DIN_WIDTH-1:0]   sw_raw,
  input  logic [2*NUM_PB-1:0]    edge_mode,
  input  logic [NUM_PB-1:0]      sticky_clr,
  input  logic                   din_ack,
  output logic [NUM_PB-1:0]      pb_level,
  output logic [NUM_PB-1:0]      pb_pulse,
  output logic [NUM_PB-1:0]      pb_sticky,
  output logic [DIN_WIDTH-1:0]   din_latched,
  output logic                   din_valid,
  output logic                   din_overrun
);

  localparam int DEB_CNT = DEBOUNCE_NS / CLK_PERIOD_NS;
  localparam int CW      = $clog2(DEB_CNT + 1);
  localparam int NB      = NUM_PB + DIN_WIDTH;

  // Buttons and switches share one debounce path; the button bits carry the
  // raw idle level so the synchronisers come out of reset looking "not pressed".
  localparam logic [NB-1:0] RAW_IDLE = {{DIN_WIDTH{1'b0}}, {NUM_PB{PB_ACTIVE_LOW}}};

  logic [NB-1:0]     sync1;
  logic [NB-1:0]     sync2;
  logic [NB-1:0]     cond;
  logic [NB-1:0]     stable;
  logic [CW-1:0]     cnt [NB];

  logic [NUM_PB-1:0]    level_q;
  logic [NUM_PB-1:0]    press;
  logic [NUM_PB-1:0]    release_ev;
  logic [NUM_PB-1:0]    pulse_next;
  logic [DIN_WIDTH-1:0] sw_stable;
  logic                 latch;

  assign cond      = sync2 ^ RAW_IDLE;
  assign pb_level  = stable[NUM_PB-1:0];
  assign sw_stable = stable[NB-1:NUM_PB];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= {sw_raw, pb_raw};
      sync2 <= sync1;
    end
  end

  // Counter tracks consecutive cycles of disagreement; the last count commits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (cond[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CNT - 1)) begin
          stable[i] <= cond[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press      = pb_level & ~level_q;
    release_ev = ~pb_level & level_q;
    pulse_next = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      pulse_next[i] = (press[i] & edge_mode[2*i]) | (release_ev[i] & edge_mode[2*i+1]);
    end
  end

  assign latch = press[LATCH_PB];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q   <= '0;
      pb_pulse  <= '0;
      pb_sticky <= '0;
    end else begin
      level_q   <= pb_level;
      pb_pulse  <= pulse_next;
      pb_sticky <= (pb_sticky & ~sticky_clr) | pb_pulse;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      din_latched <= '0;
      din_valid   <= 1'b0;
      din_overrun <= 1'b0;
    end else if (latch) begin
      din_latched <= sw_stable;
      din_valid   <= 1'b1;
      din_overrun <= din_valid & ~din_ack;
    end else if (din_ack && din_valid) begin
      din_valid   <= 1'b0;
      din_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_frontend.sv
// Scoreboard bench for input_frontend: a sample-window reference model queues the
// expected outputs per clock and a negedge monitor compares them against the DUT.
module tb_input_frontend;

  localparam int NUM_PB        = 4;
  localparam int DIN_WIDTH     = 8;
  localparam int CLK_PERIOD_NS = 20;
  localparam int DEBOUNCE_NS   = 100;
  localparam int LATCH_PB      = 3;
  localparam bit PB_ACTIVE_LOW = 1'b1;
  localparam int DEB_CNT       = DEBOUNCE_NS / CLK_PERIOD_NS;
  localparam int NB            = NUM_PB + DIN_WIDTH;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [NUM_PB-1:0]     pb_raw;
  logic [DIN_WIDTH-1:0]  sw_raw;
  logic [2*NUM_PB-1:0]   edge_mode;
  logic [NUM_PB-1:0]     sticky_clr;
  logic                  din_ack;
  logic [NUM_PB-1:0]     pb_level;
  logic [NUM_PB-1:0]     pb_pulse;
  logic [NUM_PB-1:0]     pb_sticky;
  logic [DIN_WIDTH-1:0]  din_latched;
  logic                  din_valid;
  logic                  din_overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #(CLK_PERIOD_NS/2) clk = ~clk;

  input_frontend #(
    .NUM_PB(NUM_PB), .DIN_WIDTH(DIN_WIDTH), .CLK_PERIOD_NS(CLK_PERIOD_NS),
    .DEBOUNCE_NS(DEBOUNCE_NS), .LATCH_PB(LATCH_PB), .PB_ACTIVE_LOW(PB_ACTIVE_LOW)
  ) dut (
    .clk(clk), .resetn(resetn), .pb_raw(pb_raw), .sw_raw(sw_raw),
    .edge_mode(edge_mode), .sticky_clr(sticky_clr), .din_ack(din_ack),
    .pb_level(pb_level), .pb_pulse(pb_pulse), .pb_sticky(pb_sticky),
    .din_latched(din_latched), .din_valid(din_valid), .din_overrun(din_overrun)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  typedef struct {
    logic [NUM_PB-1:0]    level;
    logic [NUM_PB-1:0]    pulse;
    logic [NUM_PB-1:0]    sticky;
    logic [DIN_WIDTH-1:0] din;
    logic                 valid;
    logic                 overrun;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a bit's debounced level follows its (polarity-corrected)
  // raw value once that value has been sampled DEB_CNT times in a row, seen
  // two samples late through the synchroniser.  Events appear one cycle later.
  logic [NB-1:0]        hist[$];
  logic [NUM_PB-1:0]    m_lvl, m_lvl_d, m_pulse, m_sticky, m_press, m_rel, m_new_pulse;
  logic [DIN_WIDTH-1:0] m_sw, m_din;
  logic                 m_valid, m_ovr;

  task automatic model_reset();
    hist.delete();
    repeat (DEB_CNT + 2) hist.push_back('0);
    m_lvl = '0; m_lvl_d = '0; m_pulse = '0; m_sticky = '0;
    m_sw = '0; m_din = '0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      model_reset();
    end else begin
      logic [NUM_PB-1:0] pressed_now;
      exp_t e;
      pressed_now = PB_ACTIVE_LOW ? ~pb_raw : pb_raw;
      hist.push_back({sw_raw, pressed_now});
      void'(hist.pop_front());

      m_press = m_lvl & ~m_lvl_d;
      m_rel   = ~m_lvl & m_lvl_d;
      for (int i = 0; i < NUM_PB; i++)
        m_new_pulse[i] = (m_press[i] && edge_mode[2*i]) || (m_rel[i] && edge_mode[2*i+1]);
      m_sticky = (m_sticky & ~sticky_clr) | m_pulse;
      m_pulse  = m_new_pulse;

      if (m_press[LATCH_PB]) begin
        m_ovr   = m_valid && !din_ack;
        m_din   = m_sw;
        m_valid = 1'b1;
      end else if (din_ack && m_valid) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end

      m_lvl_d = m_lvl;
      for (int b = 0; b < NB; b++) begin
        logic v, same, cur;
        v = hist[0][b];
        same = 1'b1;
        for (int k = 1; k < DEB_CNT; k++) if (hist[k][b] != v) same = 1'b0;
        cur = (b < NUM_PB) ? m_lvl[b] : m_sw[b-NUM_PB];
        if (same && v != cur) begin
          if (b < NUM_PB) m_lvl[b] = v;
          else m_sw[b-NUM_PB] = v;
        end
      end

      e.level = m_lvl; e.pulse = m_pulse; e.sticky = m_sticky;
      e.din = m_din; e.valid = m_valid; e.overrun = m_ovr;
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_level", pb_level, 0);
      chk("rst_pulse", pb_pulse, 0);
      chk("rst_sticky", pb_sticky, 0);
      chk("rst_din", din_latched, 0);
      chk("rst_valid", din_valid, 0);
      chk("rst_overrun", din_overrun, 0);
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_level", pb_level, e.level);
      chk("sb_pulse", pb_pulse, e.pulse);
      chk("sb_sticky", pb_sticky, e.sticky);
      chk("sb_din", din_latched, e.din);
      chk("sb_valid", din_valid, e.valid);
      chk("sb_overrun", din_overrun, e.overrun);
    end
  end

  task automatic nstep(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pstep(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    resetn = 1'b1;
    pb_raw = '1; sw_raw = '0; edge_mode = '0; sticky_clr = '0; din_ack = 1'b0;
    #1 resetn = 1'b0;
    nstep(3);
    resetn = 1'b1;
    nstep(5);

    // press on pb0 in press mode: level at edge 7, pulse at edge 8
    edge_mode[1:0] = 2'b01;
    pb_raw[0] = 1'b0;
    pstep(6);
    chk("t1_level_e6", pb_level[0], 0);
    pstep(1);
    chk("t1_level_e7", pb_level[0], 1);
    pstep(1);
    chk("t1_pulse_e8", pb_pulse[0], 1);
    pstep(1);
    chk("t1_pulse_e9", pb_pulse[0], 0);
    chk("t1_sticky", pb_sticky[0], 1);
    nstep(12);
    pb_raw[0] = 1'b1;
    nstep(20);

    // short glitch on pb1 never propagates
    edge_mode[3:2] = 2'b11;
    pb_raw[1] = 1'b0;
    nstep(4);
    pb_raw[1] = 1'b1;
    nstep(15);
    chk("t2_sticky", pb_sticky[1], 0);

    // release-only mode on pb2
    edge_mode[5:4] = 2'b10;
    pb_raw[2] = 1'b0;
    nstep(20);
    chk("t3_no_press_evt", pb_sticky[2], 0);
    pb_raw[2] = 1'b1;
    nstep(20);
    chk("t3_release_evt", pb_sticky[2], 1);

    // sticky clear coinciding with a new pulse: set wins, then clears
    pb_raw[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (pb_pulse[0]) found = 1'b1;
    end
    chk("t4_pulse_seen", found, 1);
    #1 sticky_clr[0] = 1'b1;
    nstep(1);
    chk("t4_set_wins", pb_sticky[0], 1);
    nstep(1);
    chk("t4_cleared", pb_sticky[0], 0);
    sticky_clr[0] = 1'b0;
    pb_raw[0] = 1'b1;
    nstep(15);

    // latch path with overrun and ack
    sw_raw = 8'hA5;
    nstep(10);
    pb_raw[3] = 1'b0; nstep(12);
    pb_raw[3] = 1'b1; nstep(12);
    chk("t5_din_a5", din_latched, 8'hA5);
    chk("t5_valid", din_valid, 1);
    sw_raw = 8'h3C;
    nstep(10);
    pb_raw[3] = 1'b0; nstep(12);
    pb_raw[3] = 1'b1; nstep(12);
    chk("t5_din_3c", din_latched, 8'h3C);
    chk("t5_overrun", din_overrun, 1);
    din_ack = 1'b1; nstep(1);
    din_ack = 1'b0; nstep(1);
    chk("t5_ack_valid", din_valid, 0);
    chk("t5_ack_overrun", din_overrun, 0);
    chk("t5_ack_din", din_latched, 8'h3C);

    // latch with ack held across the press (latch and ack together)
    sw_raw = 8'h5A;
    din_ack = 1'b1;
    nstep(8);
    pb_raw[3] = 1'b0; nstep(12);
    pb_raw[3] = 1'b1; nstep(4);
    din_ack = 1'b0; nstep(8);
    chk("t5b_din_5a", din_latched, 8'h5A);

    // reset mid-debounce, then debounce from scratch after release
    pb_raw[0] = 1'b0;
    pstep(3);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_level", pb_level, 0);
    chk("t6_rst_sticky", pb_sticky, 0);
    chk("t6_rst_din", din_latched, 0);
    chk("t6_rst_valid", din_valid, 0);
    nstep(3);
    resetn = 1'b1;
    pstep(6);
    chk("t6_level_e6", pb_level[0], 0);
    pstep(1);
    chk("t6_level_e7", pb_level[0], 1);
    nstep(5);
    pb_raw[0] = 1'b1;
    nstep(12);

    // randomised traffic
    edge_mode = 8'hE4;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NUM_PB; i++)
        if ($urandom_range(0, 15) == 0) pb_raw[i] = ~pb_raw[i];
      if ($urandom_range(0, 40) == 0) sw_raw = DIN_WIDTH'($urandom);
      if ($urandom_range(0, 120) == 0) edge_mode = (2*NUM_PB)'($urandom);
      sticky_clr = ($urandom_range(0, 7) == 0) ? NUM_PB'($urandom) : '0;
      din_ack = ($urandom_range(0, 5) == 0);
    end
    nstep(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
